// File: rtl/whack_pkg.sv
// Shared constants, FSM encoding and small encode helpers for the whack-a-mole input path.
package whack_pkg;

  localparam int NUM_HOLES        = 8;
  localparam int HOLE_IDX_W       = 3;
  localparam int DEBOUNCE_MAX_DEF = 1000000;  // 20 ms at 50 MHz
  localparam int CNT_W_DEF        = 20;

  // IDLE accepts a new whack; LOCK waits for every button to be released.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } fsm_state_e;

  // Index of the lowest set bit; lowest hole wins on simultaneous presses.
  function automatic logic [HOLE_IDX_W-1:0] lowest_set_idx(input logic [NUM_HOLES-1:0] v);
    logic [HOLE_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_HOLES - 1; i >= 0; i--) begin
      if (v[i]) idx = HOLE_IDX_W'(i);
    end
    return idx;
  endfunction

  // True when two or more bits are set (clearing the lowest set bit leaves something).
  function automatic logic more_than_one(input logic [NUM_HOLES-1:0] v);
    return (v & (v - NUM_HOLES'(1))) != '0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser followed by a change-qualifying debounce counter.
// The counter clears at DEBOUNCE_MAX-1, so it never wraps provided 2**CNT_W > DEBOUNCE_MAX.
module btn_debounce
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_MAX = DEBOUNCE_MAX_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Accept a new level only after it has differed from the stable level for DEBOUNCE_MAX cycles.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counter and stable level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= btn_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/whack_input_decoder.sv
// Whack-a-mole input decoder: debounces 8 buttons, detects press edges and emits one
// registered whack event (index, hit/miss, multi-press) per press, then locks out until
// all buttons are released.
//
// Event interface: press_valid is a single-cycle pulse with no back-pressure (no ready);
// press_idx, hit, miss and multi_press are meaningful only in the cycle press_valid is high,
// except press_idx which holds the last accepted index until the next event or reset.
module whack_input_decoder
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_MAX = DEBOUNCE_MAX_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_HOLES-1:0]  button,
  input  logic [HOLE_IDX_W-1:0] mole_pos,
  input  logic                  mole_active,
  output logic                  press_valid,
  output logic [HOLE_IDX_W-1:0] press_idx,
  output logic                  hit,
  output logic                  miss,
  output logic                  multi_press,
  output logic [NUM_HOLES-1:0]  stable_btn
);

  fsm_state_e            state_q;
  logic [NUM_HOLES-1:0]  stable_dly_q;
  logic [NUM_HOLES-1:0]  rise;
  logic [HOLE_IDX_W-1:0] sel_idx;
  logic                  judged_hit;
  logic                  press_valid_q;
  logic [HOLE_IDX_W-1:0] press_idx_q;
  logic                  hit_q;
  logic                  miss_q;
  logic                  multi_press_q;

  for (genvar g = 0; g < NUM_HOLES; g++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_MAX (DEBOUNCE_MAX),
      .CNT_W        (CNT_W)
    ) u_deb (
      .clk_i    (clk),
      .rst_ni   (reset),
      .btn_i    (button[g]),
      .stable_o (stable_btn[g])
    );
  end

  // Debounced levels delayed one cycle for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_dly_q <= '0;
    end else begin
      stable_dly_q <= stable_btn;
    end
  end

  // Press edges, priority pick and hit judgement against the mole seen this cycle.
  always_comb begin
    rise       = stable_btn & ~stable_dly_q;
    sel_idx    = lowest_set_idx(rise);
    judged_hit = mole_active && (sel_idx == mole_pos);
  end

  // Accept/lockout FSM with registered event outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      press_valid_q <= 1'b0;
      press_idx_q   <= '0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      multi_press_q <= 1'b0;
    end else begin
      press_valid_q <= 1'b0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      multi_press_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise != '0) begin
            press_valid_q <= 1'b1;
            press_idx_q   <= sel_idx;
            hit_q         <= judged_hit;
            miss_q        <= !judged_hit;
            multi_press_q <= more_than_one(rise);
            state_q       <= LOCK;
          end
        end
        LOCK: begin
          if (stable_btn == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign press_valid = press_valid_q;
  assign press_idx   = press_idx_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign multi_press = multi_press_q;

endmodule

// File: tb/tb_whack_input_decoder.sv
// Bench for whack_input_decoder with a short debounce window.
module tb_whack_input_decoder;

  localparam int DMAX = 4;
  localparam int CW   = 3;

  logic       clk;
  logic       reset;
  logic [7:0] button;
  logic [2:0] mole_pos;
  logic       mole_active;
  logic       press_valid;
  logic [2:0] press_idx;
  logic       hit;
  logic       miss;
  logic       multi_press;
  logic [7:0] stable_btn;

  int n_cmp = 0;
  int n_bad = 0;

  whack_input_decoder #(
    .DEBOUNCE_MAX (DMAX),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button      (button),
    .mole_pos    (mole_pos),
    .mole_active (mole_active),
    .press_valid (press_valid),
    .press_idx   (press_idx),
    .hit         (hit),
    .miss        (miss),
    .multi_press (multi_press),
    .stable_btn  (stable_btn)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A level is accepted once the synchronised input has disagreed with the accepted
  // level for DMAX consecutive clock edges (tracked as "edge of last agreement").
  logic [7:0] m_s1, m_s2, m_stable, m_stable_prev, m_rise, m_next;
  int         m_agree [8];
  int         m_cyc;
  logic       m_locked;
  logic       e_valid, e_hit, e_miss, e_multi;
  logic [2:0] e_idx;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_stable_prev = '0;
      m_cyc = 0; m_locked = 1'b0;
      for (int i = 0; i < 8; i++) m_agree[i] = 0;
      e_valid = 0; e_hit = 0; e_miss = 0; e_multi = 0; e_idx = 3'd0;
    end else begin
      m_cyc++;
      m_rise = m_stable & ~m_stable_prev;
      e_valid = 0; e_hit = 0; e_miss = 0; e_multi = 0;
      if (!m_locked && m_rise != 8'h00) begin
        e_valid = 1;
        for (int i = 7; i >= 0; i--) if (m_rise[i]) e_idx = 3'(i);
        e_hit   = mole_active && (e_idx == mole_pos);
        e_miss  = !e_hit;
        e_multi = ($countones(m_rise) > 1);
        m_locked = 1'b1;
      end else if (m_locked && m_stable == 8'h00) begin
        m_locked = 1'b0;
      end
      m_next = m_stable;
      for (int i = 0; i < 8; i++) begin
        if (m_s2[i] == m_stable[i]) m_agree[i] = m_cyc;
        else if (m_cyc - m_agree[i] >= DMAX) begin
          m_next[i] = m_s2[i];
          m_agree[i] = m_cyc;
        end
      end
      m_stable_prev = m_stable;
      m_stable = m_next;
      m_s2 = m_s1;
      m_s1 = button;
    end
  end

  // Every cycle, mid-period, the DUT must match the model.
  always @(negedge clk) begin
    check("stable_btn", 32'(stable_btn), 32'(m_stable));
    check("press_valid", 32'(press_valid), 32'(e_valid));
    check("press_idx", 32'(press_idx), 32'(e_idx));
    check("hit", 32'(hit), 32'(e_hit));
    check("miss", 32'(miss), 32'(e_miss));
    check("multi_press", 32'(multi_press), 32'(e_multi));
  end

  // ---------------- driver ----------------
  // Drive btn, step n cycles, release after 'hold' cycles (0 = keep held), record events.
  task automatic watch(input logic [7:0] btn, input int hold, input int n,
                       output int ev, output int first_cyc, output logic [2:0] idx,
                       output logic h, output logic m, output logic mu, output logic [7:0] st_or);
    ev = 0; first_cyc = 0; idx = 3'd0; h = 0; m = 0; mu = 0; st_or = 8'h00;
    button = btn;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      st_or |= stable_btn;
      if (press_valid) begin
        ev++;
        if (first_cyc == 0) first_cyc = c;
        idx = press_idx; h = hit; m = miss; mu = multi_press;
      end
      if (hold > 0 && c == hold) button = 8'h00;
    end
  endtask

  typedef struct {
    logic [7:0] btn;
    logic [2:0] pos;
    logic       act;
    int         hold;
    int         exp_ev;
    int         exp_cyc;
    logic [2:0] exp_idx;
    logic       exp_hit;
    logic       exp_multi;
    logic [7:0] exp_st_or;
  } vec_t;

  vec_t vecs [7];

  int         ev, fc;
  logic [2:0] idx;
  logic       h, m, mu;
  logic [7:0] st_or;

  initial begin
    // glitch, exact-window pulse, hit, miss, simultaneous, inactive mole, all buttons
    vecs[0] = '{8'h08, 3'd3, 1'b1, 3,  0, 0, 3'd0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{8'h08, 3'd3, 1'b1, 4,  1, 7, 3'd3, 1'b1, 1'b0, 8'h08};
    vecs[2] = '{8'h20, 3'd5, 1'b1, 12, 1, 7, 3'd5, 1'b1, 1'b0, 8'h20};
    vecs[3] = '{8'h40, 3'd2, 1'b1, 12, 1, 7, 3'd6, 1'b0, 1'b0, 8'h40};
    vecs[4] = '{8'hA0, 3'd7, 1'b1, 12, 1, 7, 3'd5, 1'b0, 1'b1, 8'hA0};
    vecs[5] = '{8'h02, 3'd1, 1'b0, 12, 1, 7, 3'd1, 1'b0, 1'b0, 8'h02};
    vecs[6] = '{8'hFF, 3'd0, 1'b1, 12, 1, 7, 3'd0, 1'b1, 1'b1, 8'hFF};

    // Reset held with every button pressed.
    reset = 1'b0; button = 8'hFF; mole_pos = 3'd3; mole_active = 1'b1;
    repeat (3) @(negedge clk);
    check("rst press_valid", 32'(press_valid), 32'd0);
    check("rst press_idx", 32'(press_idx), 32'd0);
    check("rst hit_miss_multi", 32'({hit, miss, multi_press}), 32'd0);
    check("rst stable_btn", 32'(stable_btn), 32'd0);

    // Release reset: stable at edge 6, single event at edge 7.
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_rel stable@5", 32'(stable_btn), 32'h00);
    @(negedge clk);
    check("rst_rel stable@6", 32'(stable_btn), 32'hFF);
    watch(8'hFF, 0, 10, ev, fc, idx, h, m, mu, st_or);
    check("rst_rel events", 32'(ev), 32'd1);
    check("rst_rel event cycle", 32'(fc), 32'd1);
    check("rst_rel idx", 32'(idx), 32'd0);
    check("rst_rel multi", 32'(mu), 32'd1);
    watch(8'h00, 0, 14, ev, fc, idx, h, m, mu, st_or);
    check("release events", 32'(ev), 32'd0);

    // Table of single-press scenarios.
    foreach (vecs[k]) begin
      mole_pos = vecs[k].pos; mole_active = vecs[k].act;
      watch(vecs[k].btn, vecs[k].hold, vecs[k].hold + 14, ev, fc, idx, h, m, mu, st_or);
      check($sformatf("vec%0d events", k), 32'(ev), 32'(vecs[k].exp_ev));
      check($sformatf("vec%0d stable_seen", k), 32'(st_or), 32'(vecs[k].exp_st_or));
      if (vecs[k].exp_ev > 0) begin
        check($sformatf("vec%0d cycle", k), 32'(fc), 32'(vecs[k].exp_cyc));
        check($sformatf("vec%0d idx", k), 32'(idx), 32'(vecs[k].exp_idx));
        check($sformatf("vec%0d hit", k), 32'(h), 32'(vecs[k].exp_hit));
        check($sformatf("vec%0d miss", k), 32'(m), 32'(!vecs[k].exp_hit));
        check($sformatf("vec%0d multi", k), 32'(mu), 32'(vecs[k].exp_multi));
      end
    end

    // Lockout: miss on 6, then 2 pressed while 6 held gives nothing.
    mole_pos = 3'd2; mole_active = 1'b1;
    watch(8'h40, 0, 12, ev, fc, idx, h, m, mu, st_or);
    check("lock first events", 32'(ev), 32'd1);
    check("lock first idx", 32'(idx), 32'd6);
    check("lock first miss", 32'(m), 32'd1);
    watch(8'h44, 0, 15, ev, fc, idx, h, m, mu, st_or);
    check("lock swallowed", 32'(ev), 32'd0);
    watch(8'h00, 0, 14, ev, fc, idx, h, m, mu, st_or);
    check("lock release", 32'(ev), 32'd0);
    watch(8'h04, 12, 26, ev, fc, idx, h, m, mu, st_or);
    check("lock after idx", 32'(idx), 32'd2);
    check("lock after hit", 32'(h), 32'd1);

    // Inactive mole then async reset while locked.
    mole_pos = 3'd1; mole_active = 1'b0;
    watch(8'h02, 0, 10, ev, fc, idx, h, m, mu, st_or);
    check("inact miss", 32'(m), 32'd1);
    check("inact idx", 32'(idx), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midlock stable", 32'(stable_btn), 32'h00);
    check("midlock idx", 32'(press_idx), 32'd0);
    check("midlock pulses", 32'({press_valid, hit, miss, multi_press}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    watch(8'h02, 0, 12, ev, fc, idx, h, m, mu, st_or);
    check("post_rst events", 32'(ev), 32'd1);
    check("post_rst cycle", 32'(fc), 32'd7);
    check("post_rst idx", 32'(idx), 32'd1);
    watch(8'h00, 0, 14, ev, fc, idx, h, m, mu, st_or);

    // Random presses and glitches, checked against the model every cycle.
    for (int it = 0; it < 250; it++) begin
      logic [7:0] b;
      case ($urandom_range(0, 3))
        0: b = 8'h00;
        1: b = 8'(1 << $urandom_range(0, 7));
        2: b = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
        default: b = 8'($urandom_range(0, 255));
      endcase
      mole_pos = 3'($urandom_range(0, 7));
      mole_active = 1'($urandom_range(0, 1));
      button = b;
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end
    button = 8'h00;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
